// File: rtl/calc_key_entry.sv
// Keypad operand-entry stage: builds two 0..99 decimal operands from key events and
// commits the selected operation to the calculator on the equals key.
module calc_key_entry (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [6:0] operand_a,
  output logic [6:0] operand_b,
  output logic [3:0] op_code,
  output logic       result_valid,
  output logic [1:0] entry_state,
  output logic [1:0] digit_count
);

  localparam int unsigned MaxDigits = 2;
  localparam logic [3:0]  KeyAdd    = 4'd10;
  localparam logic [3:0]  KeySub    = 4'd11;
  localparam logic [3:0]  KeyMul    = 4'd12;
  localparam logic [3:0]  KeyClr    = 4'd13;
  localparam logic [3:0]  KeyEq     = 4'd14;
  localparam logic [3:0]  OpIdle    = 4'd0;

  typedef enum logic [1:0] {
    StEnterA  = 2'd0,
    StEnterB  = 2'd1,
    StShowRes = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] opa_q, opa_d;
  logic [6:0] opb_q, opb_d;
  logic [3:0] op_code_q, op_code_d;
  logic       rv_q, rv_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] pending_q, pending_d;

  logic is_digit, is_oper, is_clr, is_eq, digit_ok, state_bad;

  // x*10 + d as x*8 + x*2 + d; only used while x <= 9, so it never exceeds 99.
  function automatic logic [6:0] acc10(input logic [6:0] v, input logic [3:0] d);
    return (v << 3) + (v << 1) + {3'b000, d};
  endfunction

  always_comb begin
    is_digit  = key_valid && (key_code <= 4'd9);
    is_oper   = key_valid && (key_code == KeyAdd || key_code == KeySub || key_code == KeyMul);
    is_clr    = key_valid && (key_code == KeyClr);
    is_eq     = key_valid && (key_code == KeyEq);
    digit_ok  = is_digit && (cnt_q < 2'(MaxDigits));
    state_bad = !(state_q inside {StEnterA, StEnterB, StShowRes});
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StEnterA;
      opa_q     <= '0;
      opb_q     <= '0;
      op_code_q <= OpIdle;
      rv_q      <= 1'b0;
      cnt_q     <= '0;
      pending_q <= KeyAdd;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_code_q <= op_code_d;
      rv_q      <= rv_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEnterA: begin
        if (is_clr)       state_d = StEnterA;
        else if (is_oper) state_d = StEnterB;
      end
      StEnterB: begin
        if (is_clr)                        state_d = StEnterA;
        else if (is_eq && cnt_q != 2'd0)   state_d = StShowRes;
      end
      StShowRes: begin
        if (is_clr || is_digit) state_d = StEnterA;
      end
      default: state_d = StEnterA;
    endcase
  end

  // Datapath next values; clear (and an illegal state) override everything else.
  always_comb begin
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_code_d = op_code_q;
    rv_d      = 1'b0;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (is_clr || state_bad) begin
      opa_d     = '0;
      opb_d     = '0;
      cnt_d     = '0;
      pending_d = KeyAdd;
      op_code_d = KeyClr;
    end else begin
      case (state_q)
        StEnterA: begin
          if (digit_ok) begin
            opa_d     = acc10(opa_q, key_code);
            cnt_d     = cnt_q + 2'd1;
            op_code_d = OpIdle;
          end else if (is_oper) begin
            pending_d = key_code;
            opb_d     = '0;
            cnt_d     = '0;
          end
        end
        StEnterB: begin
          if (digit_ok) begin
            opb_d     = acc10(opb_q, key_code);
            cnt_d     = cnt_q + 2'd1;
            op_code_d = OpIdle;
          end else if (is_oper && cnt_q == 2'd0) begin
            pending_d = key_code;
          end else if (is_eq && cnt_q != 2'd0) begin
            op_code_d = pending_q;
            rv_d      = 1'b1;
          end
        end
        StShowRes: begin
          // No chaining: a digit always starts a fresh calculation.
          if (is_digit) begin
            opa_d     = {3'b000, key_code};
            opb_d     = '0;
            cnt_d     = 2'd1;
            op_code_d = OpIdle;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are straight register taps.
  always_comb begin
    operand_a    = opa_q;
    operand_b    = opb_q;
    op_code      = op_code_q;
    result_valid = rv_q;
    entry_state  = state_q;
    digit_count  = cnt_q;
  end

endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
- Keypad operand-entry stage that sits directly upstream of the calculator arithmetic block.
- Consumes one-cycle key events from the keypad scanner/debouncer.
- Assembles two decimal operands of up to 2 digits each (0..99), latches the selected operation, and presents operand_a, operand_b and op_code to the calculator's In1, In2 and keyboard inputs.
- Also tells the display mux which value to show.

Parameters:
- MAX_DIGITS, 2, digits accepted per operand; fixed at 2 so the value stays at or below 99 and fits in 7 bits.
- KEY_ADD, 4'd10, add key code.
- KEY_SUB, 4'd11, subtract key code.
- KEY_MUL, 4'd12, multiply key code.
- KEY_CLR, 4'd13, clear key code.
- KEY_EQ, 4'd14, equals key code.
- OP_IDLE, 4'd0, op_code value while no operation is committed.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- key_valid  input  1  one-cycle strobe; key_code is valid in that cycle.
- key_code  input  4  0-9 digit; 10-12 operator; 13 clear; 14 equals; 15 ignored.
- operand_a  output  7  first operand, binary, 0..99; drives calculator In1.
- operand_b  output  7  second operand, binary, 0..99; drives calculator In2.
- op_code  output  4  operation presented to the calculator's keyboard input.
- result_valid  output  1  one-cycle pulse when equals commits an operation.
- entry_state  output  2  0 = ENTER_A, 1 = ENTER_B, 2 = SHOW_RES; used as the display select.
- digit_count  output  2  digits entered into the operand currently being edited (0..2).

Behaviour:
- Reset: when rst_n is low at a clk edge, all of the following load together.
  - operand_a = 0, operand_b = 0, op_code = OP_IDLE, result_valid = 0, entry_state = ENTER_A, digit_count = 0.
  - Internal pending_op = KEY_ADD.
- Reset mid-entry discards all partial state. key_valid is ignored in any cycle where rst_n is low.
- Key sampling:
  - Only cycles with key_valid = 1 are events; every such cycle is one press.
  - Outputs update at the clk edge ending the event cycle (1-cycle latency).
  - key_code 15 is a no-op in every state.
- Digit accumulation:
  - new = old*10 + d, computed in 7 bits (old*8 + old*2 + d; maximum 99, no overflow).
  - A digit arriving when digit_count = 2 is ignored.
  - Leading zeros count as digits, so "0","5" gives 5 with digit_count = 2.
- ENTER_A:
  - Digit: accumulates into operand_a; digit_count increments; op_code = OP_IDLE.
  - Operator 10-12: pending_op = key; operand_b = 0; digit_count = 0; go to ENTER_B. If no digits were entered, operand_a stays 0.
  - Equals: ignored.
- ENTER_B:
  - Digit: accumulates into operand_b.
  - Operator 10-12: replaces pending_op only if digit_count = 0; otherwise ignored.
  - Equals with digit_count = 0: ignored.
  - Equals with digit_count > 0: op_code = pending_op; result_valid = 1 for exactly one cycle; go to SHOW_RES. operand_a and operand_b hold.
- SHOW_RES:
  - op_code stays at pending_op so the downstream result remains stable.
  - Digit: starts a new calculation. operand_a = d, operand_b = 0, digit_count = 1, op_code = OP_IDLE, go to ENTER_A.
  - Operator and equals: ignored; no chaining, because a 32-bit result cannot re-enter a 7-bit operand.
- Clear (13), any state:
  - operand_a = 0, operand_b = 0, digit_count = 0, pending_op = KEY_ADD, go to ENTER_A.
  - op_code = KEY_CLR; it holds until the next accepted digit, which sets op_code = OP_IDLE.
  - Clear takes priority over any pending behaviour.
- result_valid is never asserted for two consecutive cycles. It is 0 in every cycle not immediately following a committing equals.
- Illegal entry_state encoding 3 recovers to ENTER_A with the clear-key effects.

Test Plan:
- Reset, then keys 4,2,A,1,7,E → operand_a = 42, operand_b = 17, op_code = 10, result_valid high for one cycle after E, entry_state = 2.
- Keys 9,9,9 → operand_a = 99, digit_count = 2; third 9 ignored; then C,9,9,E → op_code = 12, operand_b = 99.
- Keys 5,B,C,3,E → pending op replaced, op_code = 12. Keys 5,B,3,A,E → A ignored after digit, op_code = 11.
- Keys 7,A,E → equals ignored (entry_state = 1, result_valid = 0); then 2,E → commit with operand_b = 2.
- Mid-entry 6,A,8 then D → operand_a = 0, operand_b = 0, op_code = 13, entry_state = 0; next digit 3 → op_code = 0, operand_a = 3.
- From SHOW_RES, key 4 → operand_a = 4, operand_b = 0, entry_state = 0. rst_n low for one cycle while key_valid = 1 with key 5 → all outputs at reset values, key ignored.
